// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the capture run controller: CTRL bits, register offsets, state encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a; the register bus is write-only and never stalls.
package capture_sequencer_pkg;

  // CTRL register bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_TIMED = 2;
  localparam int CTRL_CLR   = 3;

  // Register offsets relative to BASE_ADDR; DURATION is little-endian
  localparam logic [7:0] OFF_CTRL = 8'd0;
  localparam logic [7:0] OFF_DUR0 = 8'd1;
  localparam logic [7:0] OFF_DUR1 = 8'd2;
  localparam logic [7:0] OFF_DUR2 = 8'd3;
  localparam logic [7:0] OFF_DUR3 = 8'd4;

  // Run controller states; ARMED only exists when the external trigger is built in
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
`ifdef CAPTURE_TRIGGER_EN
    , ST_ARMED = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/capture_sequencer_if.sv
// Register write bus shared with reg_manager (address, data, one-cycle strobe).
// Latency: n/a (wires only).
// Backpressure: none; every strobed write is taken in the cycle it is presented.
interface capture_sequencer_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_wr;

  modport master (output reg_addr, output reg_data, output reg_wr);
  modport slave  (input  reg_addr, input  reg_data, input  reg_wr);
endinterface

// File: rtl/capture_sequencer_trigger_sync.sv
// Brings the asynchronous start trigger into clk and flags its rising edge (used with CAPTURE_TRIGGER_EN).
// Latency: trigger_rise is high in the 2nd cycle after the input edge is first sampled.
// Backpressure: none; a level held for less than one clk period may be missed.
module capture_trigger_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger_in,
  output logic trigger_rise
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  // Two-flop synchronizer plus one delay stage for the edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
    end else begin
      sync_1   <= trigger_in;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
    end
  end

  assign trigger_rise = sync_2 & ~sync_2_d;

endmodule

// File: rtl/capture_sequencer.sv
// Capture run controller: decodes CTRL/DURATION writes, sequences optional counter clear then acquisition.
// Latency: register writes take effect on the following cycle; all outputs are registered.
// Backpressure: none; writes arriving in a state that cannot use them are dropped. Build option CAPTURE_TRIGGER_EN.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'h20,
  parameter int          RESET_CYCLES = 4,
  parameter int          COUNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  capture_sequencer_if.slave      reg_bus,
`ifdef CAPTURE_TRIGGER_EN
  input  logic                    trigger_in,
`endif
  output logic                    capture_operate,
  output logic                    timer_reset,
  output logic                    capture_done,
  output logic [COUNT_W-1:0]      elapsed
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t             state_q;
  state_t             state_nxt;
  logic [31:0]        shadow_q;
  logic [COUNT_W-1:0] countdown_q;
  logic [RC_W-1:0]    rst_cnt_q;
  logic               timed_q;

  logic [7:0]         reg_off;
  logic               ctrl_wr;
  logic               start_req;
  logic               stop_req;

  logic               load_run;
  logic               set_done;
  logic               clr_done;

`ifdef CAPTURE_TRIGGER_EN
  logic               clr_q;
  logic               trig_rise;

  capture_trigger_sync u_trigger_sync (
    .clk          (clk),
    .reset_n      (reset_n),
    .trigger_in   (trigger_in),
    .trigger_rise (trig_rise)
  );
`endif

  // STOP wins over START when both arrive in one CTRL write
  assign reg_off   = reg_bus.reg_addr - BASE_ADDR;
  assign ctrl_wr   = reg_bus.reg_wr && (reg_off == OFF_CTRL);
  assign start_req = ctrl_wr && reg_bus.reg_data[CTRL_START] && !reg_bus.reg_data[CTRL_STOP];
  assign stop_req  = ctrl_wr && reg_bus.reg_data[CTRL_STOP];

  // Next-state and run-control strobes
  always_comb begin
    state_nxt = state_q;
    load_run  = 1'b0;
    set_done  = 1'b0;
    clr_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          load_run = 1'b1;
          clr_done = 1'b1;
          if (reg_bus.reg_data[CTRL_TIMED] && (shadow_q == 32'd0)) begin
            // A zero-length timed run completes without ever acquiring
            set_done  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
`ifdef CAPTURE_TRIGGER_EN
            state_nxt = ST_ARMED;
`else
            state_nxt = reg_bus.reg_data[CTRL_CLR] ? ST_CLEAR : ST_RUN;
`endif
          end
        end
      end
`ifdef CAPTURE_TRIGGER_EN
      ST_ARMED: begin
        if (stop_req) begin
          set_done  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (trig_rise) begin
          state_nxt = clr_q ? ST_CLEAR : ST_RUN;
        end
      end
`endif
      ST_CLEAR: begin
        if (stop_req) begin
          set_done  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rst_cnt_q == '0) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // STOP and the final timed cycle coincide into one exit
        if (stop_req || (timed_q && (countdown_q == COUNT_W'(1)))) begin
          set_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // DURATION shadow; only copied into the countdown at START
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= 32'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (reg_bus.reg_wr && (reg_off == OFF_DUR0 + 8'(k))) begin
          shadow_q[8*k +: 8] <= reg_bus.reg_data;
        end
      end
    end
  end

  // Per-run mode latches and the timed-run countdown
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timed_q     <= 1'b0;
      countdown_q <= '0;
    end else if (load_run) begin
      timed_q     <= reg_bus.reg_data[CTRL_TIMED];
      countdown_q <= COUNT_W'(shadow_q);
    end else if ((state_q == ST_RUN) && timed_q) begin
      countdown_q <= countdown_q - 1'b1;
    end
  end

`ifdef CAPTURE_TRIGGER_EN
  // Clear request is held across ARMED until the trigger arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_q <= 1'b0;
    end else if (load_run) begin
      clr_q <= reg_bus.reg_data[CTRL_CLR];
    end
  end
`endif

  // Clear-pulse width counter, loaded on entry to CLEAR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt_q <= '0;
    end else if ((state_nxt == ST_CLEAR) && (state_q != ST_CLEAR)) begin
      rst_cnt_q <= RC_W'(RESET_CYCLES - 1);
    end else if ((state_q == ST_CLEAR) && (rst_cnt_q != '0)) begin
      rst_cnt_q <= rst_cnt_q - 1'b1;
    end
  end

  // Elapsed run time: cleared at START, saturating count of acquiring cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elapsed <= '0;
    end else if (load_run) begin
      elapsed <= '0;
    end else if ((state_q == ST_RUN) && (elapsed != '1)) begin
      elapsed <= elapsed + 1'b1;
    end
  end

  // Registered outputs follow the next state; done is sticky until the next START
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_operate <= 1'b0;
      timer_reset     <= 1'b0;
      capture_done    <= 1'b0;
    end else begin
      capture_operate <= (state_nxt == ST_RUN);
      timer_reset     <= (state_nxt == ST_CLEAR);
      if (set_done) begin
        capture_done <= 1'b1;
      end else if (clr_done) begin
        capture_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: register writes, run timing, status and async reset.
module tb_capture_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_operate;
  logic        timer_reset;
  logic        capture_done;
  logic [31:0] elapsed;
`ifdef CAPTURE_TRIGGER_EN
  logic        trigger_in = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int op_tot = 0;
  int tr_tot = 0;

  capture_sequencer_if bus ();

  capture_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .reg_bus         (bus.slave),
`ifdef CAPTURE_TRIGGER_EN
    .trigger_in      (trigger_in),
`endif
    .capture_operate (capture_operate),
    .timer_reset     (timer_reset),
    .capture_done    (capture_done),
    .elapsed         (elapsed)
  );

  always #5 clk = ~clk;

  // Free-running tallies of high cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (capture_operate === 1'b1) op_tot++;
    if (timer_reset === 1'b1) tr_tot++;
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.reg_addr = a;
    bus.reg_data = d;
    bus.reg_wr   = 1'b1;
    @(negedge clk);
    bus.reg_wr   = 1'b0;
  endtask

  task automatic set_dur(input logic [31:0] v);
    wr(8'h21, v[7:0]);
    wr(8'h22, v[15:8]);
    wr(8'h23, v[23:16]);
    wr(8'h24, v[31:24]);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL reset_op got=%b want=0", capture_operate); end
    total++; if (timer_reset !== 1'b0) begin bad++; $display("FAIL reset_tr got=%b want=0", timer_reset); end
    total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", capture_done); end
    total++; if (elapsed !== 32'd0) begin bad++; $display("FAIL reset_elapsed got=%0d want=0", elapsed); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL idle_op got=%b want=0", capture_operate); end
  endtask

  task automatic test_zero_duration();
    int op0;
    set_dur(32'd0);
    op0 = op_tot;
    wr(8'h20, 8'h05);
    @(negedge clk);
    #1;
    total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", capture_done); end
    total++; if (elapsed !== 32'd0) begin bad++; $display("FAIL zero_elapsed got=%0d want=0", elapsed); end
    total++; if (op_tot - op0 !== 0) begin bad++; $display("FAIL zero_op_cycles got=%0d want=0", op_tot - op0); end
  endtask

  task automatic test_timed();
    int op0, tr0;
    set_dur(32'd100);
    op0 = op_tot; tr0 = tr_tot;
    wr(8'h20, 8'h05);
    total++; if (capture_operate !== 1'b1) begin bad++; $display("FAIL timed_start got=%b want=1", capture_operate); end
    total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL timed_done_clr got=%b want=0", capture_done); end
    repeat (99) @(negedge clk);
    total++; if (capture_operate !== 1'b1) begin bad++; $display("FAIL timed_last got=%b want=1", capture_operate); end
    @(negedge clk);
    #1;
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL timed_end got=%b want=0", capture_operate); end
    total++; if (op_tot - op0 !== 100) begin bad++; $display("FAIL timed_op_cycles got=%0d want=100", op_tot - op0); end
    total++; if (elapsed !== 32'd100) begin bad++; $display("FAIL timed_elapsed got=%0d want=100", elapsed); end
    total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL timed_done got=%b want=1", capture_done); end
    total++; if (tr_tot - tr0 !== 0) begin bad++; $display("FAIL timed_tr_cycles got=%0d want=0", tr_tot - tr0); end
  endtask

  task automatic test_clear_untimed();
    int op0, tr0;
    bit seen;
    op0 = op_tot; tr0 = tr_tot;
    seen = 1'b0;
    wr(8'h20, 8'h09);
    total++; if (timer_reset !== 1'b1) begin bad++; $display("FAIL clr_tr_start got=%b want=1", timer_reset); end
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL clr_op_low got=%b want=0", capture_operate); end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (capture_operate === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL clr_run_timeout got=0 want=1"); end
    repeat (48) @(negedge clk);
    wr(8'h20, 8'h02);
    #1;
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL stop_op got=%b want=0", capture_operate); end
    total++; if (tr_tot - tr0 !== 4) begin bad++; $display("FAIL clr_tr_cycles got=%0d want=4", tr_tot - tr0); end
    total++; if (op_tot - op0 !== 50) begin bad++; $display("FAIL untimed_op_cycles got=%0d want=50", op_tot - op0); end
    total++; if (elapsed !== 32'd50) begin bad++; $display("FAIL untimed_elapsed got=%0d want=50", elapsed); end
    total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL untimed_done got=%b want=1", capture_done); end
  endtask

  task automatic test_start_stop();
    int op0;
    wr(8'h20, 8'h03);
    @(negedge clk);
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL ss_op got=%b want=0", capture_operate); end
    total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL ss_done got=%b want=1", capture_done); end
    total++; if (elapsed !== 32'd50) begin bad++; $display("FAIL ss_elapsed got=%0d want=50", elapsed); end
    set_dur(32'd20);
    op0 = op_tot;
    wr(8'h20, 8'h05);
    repeat (5) @(negedge clk);
    wr(8'h20, 8'h01);
    repeat (20) @(negedge clk);
    #1;
    total++; if (op_tot - op0 !== 20) begin bad++; $display("FAIL restart_op_cycles got=%0d want=20", op_tot - op0); end
    total++; if (elapsed !== 32'd20) begin bad++; $display("FAIL restart_elapsed got=%0d want=20", elapsed); end
    total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL restart_done got=%b want=1", capture_done); end
  endtask

  task automatic test_shadow_midrun();
    int op0;
    bit ended;
    set_dur(32'd1000);
    op0 = op_tot;
    ended = 1'b0;
    wr(8'h20, 8'h05);
    repeat (10) @(negedge clk);
    wr(8'h21, 8'h05);
    wr(8'h22, 8'h00);
    for (int i = 0; i < 1100 && !ended; i++) begin
      @(negedge clk);
      if (capture_operate === 1'b0) ended = 1'b1;
    end
    #1;
    total++; if (!ended) begin bad++; $display("FAIL long_run_timeout got=0 want=1"); end
    total++; if (op_tot - op0 !== 1000) begin bad++; $display("FAIL long_op_cycles got=%0d want=1000", op_tot - op0); end
    total++; if (elapsed !== 32'd1000) begin bad++; $display("FAIL long_elapsed got=%0d want=1000", elapsed); end
    op0 = op_tot;
    wr(8'h20, 8'h05);
    repeat (10) @(negedge clk);
    #1;
    total++; if (op_tot - op0 !== 5) begin bad++; $display("FAIL short_op_cycles got=%0d want=5", op_tot - op0); end
    total++; if (elapsed !== 32'd5) begin bad++; $display("FAIL short_elapsed got=%0d want=5", elapsed); end
  endtask

  task automatic test_async_reset();
    wr(8'h20, 8'h01);
    repeat (10) @(negedge clk);
    total++; if (capture_operate !== 1'b1) begin bad++; $display("FAIL pre_rst_op got=%b want=1", capture_operate); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL arst_op got=%b want=0", capture_operate); end
    total++; if (timer_reset !== 1'b0) begin bad++; $display("FAIL arst_tr got=%b want=0", timer_reset); end
    total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", capture_done); end
    total++; if (elapsed !== 32'd0) begin bad++; $display("FAIL arst_elapsed got=%0d want=0", elapsed); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL post_rst_op got=%b want=0", capture_operate); end
  endtask

`ifdef CAPTURE_TRIGGER_EN
  task automatic test_trigger();
    wr(8'h20, 8'h01);
    total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL armed_done got=%b want=0", capture_done); end
    repeat (19) @(negedge clk);
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL armed_op got=%b want=0", capture_operate); end
    trigger_in = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL trig_early got=%b want=0", capture_operate); end
    @(negedge clk);
    total++; if (capture_operate !== 1'b1) begin bad++; $display("FAIL trig_rise got=%b want=1", capture_operate); end
    trigger_in = 1'b0;
    wr(8'h20, 8'h02);
    wr(8'h20, 8'h01);
    wr(8'h20, 8'h02);
    total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL armed_stop_done got=%b want=1", capture_done); end
    trigger_in = 1'b1;
    repeat (6) @(negedge clk);
    trigger_in = 1'b0;
    total++; if (capture_operate !== 1'b0) begin bad++; $display("FAIL trig_ignored got=%b want=0", capture_operate); end
  endtask
`endif

  initial begin
    bus.reg_addr = 8'h00;
    bus.reg_data = 8'h00;
    bus.reg_wr   = 1'b0;
    test_reset();
    test_zero_duration();
    test_timed();
    test_clear_untimed();
    test_start_stop();
    test_shadow_midrun();
    test_async_reset();
`ifdef CAPTURE_TRIGGER_EN
    test_trigger();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
